// File: rtl/bus485_arb_m.sv
// bus485_arb_m: half-duplex RS-485 line scheduler.
// Sync (high prio) and command (low prio) share one driver.
module bus485_arb_m #(
    parameter int unsigned T_SETUP_US = 2,
    parameter int unsigned T_HOLD_US  = 2,
    parameter int unsigned T_GAP_US   = 5,
    parameter int unsigned TMO_US     = 1000
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pluse_us,
    input  logic syn_req,
    input  logic syn_tx,
    input  logic syn_done,
    output logic syn_gnt,
    input  logic cmd_req,
    input  logic cmd_tx,
    input  logic cmd_done,
    output logic cmd_gnt,
    output logic tx_ctrl,
    output logic tx_line,
    output logic busy,
    output logic tmo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_GRANT,
        S_HOLD,
        S_GAP
    } state_e;

    localparam logic [15:0] LIM_SETUP = 16'(T_SETUP_US);
    localparam logic [15:0] LIM_HOLD  = 16'(T_HOLD_US);
    localparam logic [15:0] LIM_GAP   = 16'(T_GAP_US);
    localparam logic [15:0] LIM_TMO   = 16'(TMO_US);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic        entry_q, entry_d;
    logic        own_req, own_done, own_tx;
    logic        gnt_d, tmo_d;
    logic        tx_ctrl_q, tx_ctrl_d;
    logic        tx_line_q, tx_line_d;
    logic        syn_gnt_q, syn_gnt_d;
    logic        cmd_gnt_q, cmd_gnt_d;
    logic        busy_q, busy_d;
    logic        tmo_q;

    assign own_req  = owner_q ? cmd_req  : syn_req;
    assign own_done = owner_q ? cmd_done : syn_done;
    assign own_tx   = owner_q ? cmd_tx   : syn_tx;

    // Next state, owner latch and timeout detection.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (syn_req) begin
                    state_d = S_SETUP;
                    owner_d = 1'b0;
                end else if (cmd_req) begin
                    state_d = S_SETUP;
                    owner_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (!own_req) begin
                    state_d = S_HOLD;
                end else if (cnt_q == LIM_SETUP) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (own_done) begin
                    state_d = S_HOLD;
                end else if (cnt_q == LIM_TMO) begin
                    state_d = S_HOLD;
                    tmo_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == LIM_HOLD) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == LIM_GAP) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Guard timer: cleared on entry, skips the entry-cycle strobe.
    always_comb begin
        entry_d = (state_d != state_q);
        cnt_d   = cnt_q;
        if (entry_d) begin
            cnt_d = 16'd0;
        end else if (!entry_q && pluse_us && state_q != S_IDLE) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Outputs decoded from the next state so they register cleanly.
    always_comb begin
        gnt_d     = (state_d == S_GRANT);
        syn_gnt_d = gnt_d && !owner_d;
        cmd_gnt_d = gnt_d && owner_d;
        tx_ctrl_d = (state_d == S_SETUP) || gnt_d
                 || (state_d == S_HOLD);
        busy_d    = (state_d != S_IDLE);
        tx_line_d = gnt_d ? own_tx : 1'b1;
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            cnt_q     <= 16'd0;
            entry_q   <= 1'b0;
            tx_ctrl_q <= 1'b0;
            tx_line_q <= 1'b1;
            syn_gnt_q <= 1'b0;
            cmd_gnt_q <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            tx_ctrl_q <= tx_ctrl_d;
            tx_line_q <= tx_line_d;
            syn_gnt_q <= syn_gnt_d;
            cmd_gnt_q <= cmd_gnt_d;
            busy_q    <= busy_d;
            tmo_q     <= tmo_d;
        end
    end

    assign tx_ctrl = tx_ctrl_q;
    assign tx_line = tx_line_q;
    assign syn_gnt = syn_gnt_q;
    assign cmd_gnt = cmd_gnt_q;
    assign busy    = busy_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_bus485_arb_m.sv
// tb_bus485_arb_m: random + directed bench for bus485_arb_m
// against a strobe-countdown phase model.
module tb_bus485_arb_m;

    localparam int PER = 50;
    localparam int TS  = 2;
    localparam int TH  = 2;
    localparam int TG  = 5;
    localparam int TMO = 100;

    localparam int P_IDLE  = 0;
    localparam int P_SETUP = 1;
    localparam int P_GRANT = 2;
    localparam int P_HOLD  = 3;
    localparam int P_GAP   = 4;

    logic clk_sys = 1'b0;
    logic rst_n, pluse_us;
    logic syn_req, syn_tx, syn_done;
    logic cmd_req, cmd_tx, cmd_done;
    logic syn_gnt, cmd_gnt, tx_ctrl, tx_line, busy, tmo;

    int n_cmp = 0;
    int n_bad = 0;
    int tmo_seen = 0;
    int gnt_seen = 0;
    bit chk_en = 1'b0;

    int m_ph, m_left;
    bit m_own, m_fresh, m_moved, m_tmo, m_line;

    bus485_arb_m #(
        .T_SETUP_US(TS),
        .T_HOLD_US (TH),
        .T_GAP_US  (TG),
        .TMO_US    (TMO)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pluse_us(pluse_us),
        .syn_req (syn_req),
        .syn_tx  (syn_tx),
        .syn_done(syn_done),
        .syn_gnt (syn_gnt),
        .cmd_req (cmd_req),
        .cmd_tx  (cmd_tx),
        .cmd_done(cmd_done),
        .cmd_gnt (cmd_gnt),
        .tx_ctrl (tx_ctrl),
        .tx_line (tx_line),
        .busy    (busy),
        .tmo     (tmo)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        int pc;
        pc = $urandom_range(0, PER - 1);
        pluse_us = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            pc = (pc + 1) % PER;
            pluse_us = (pc == 0);
        end
    end

    function automatic int lim(input int ph);
        case (ph)
            P_SETUP: return TS;
            P_GRANT: return TMO;
            P_HOLD:  return TH;
            P_GAP:   return TG;
            default: return 0;
        endcase
    endfunction

    task automatic go(input int ph);
        m_ph = ph;
        m_left = lim(ph);
        m_fresh = 1'b1;
        m_moved = 1'b1;
    endtask

    task automatic model_step();
        bit rq, dn;
        m_moved = 1'b0;
        m_tmo = 1'b0;
        rq = m_own ? cmd_req : syn_req;
        dn = m_own ? cmd_done : syn_done;
        case (m_ph)
            P_IDLE: begin
                if (syn_req) begin
                    m_own = 1'b0;
                    go(P_SETUP);
                end else if (cmd_req) begin
                    m_own = 1'b1;
                    go(P_SETUP);
                end
            end
            P_SETUP: begin
                if (!rq) go(P_HOLD);
                else if (m_left == 0) go(P_GRANT);
            end
            P_GRANT: begin
                if (dn) go(P_HOLD);
                else if (m_left == 0) begin
                    go(P_HOLD);
                    m_tmo = 1'b1;
                end
            end
            P_HOLD: if (m_left == 0) go(P_GAP);
            default: if (m_left == 0) go(P_IDLE);
        endcase
        if (!m_moved) begin
            if (m_fresh) m_fresh = 1'b0;
            else if (pluse_us && m_left > 0) m_left--;
        end
        if (m_ph == P_GRANT) m_line = m_own ? cmd_tx : syn_tx;
        else m_line = 1'b1;
    endtask

    function automatic logic [5:0] m_vec();
        logic on, g;
        on = (m_ph == P_SETUP) || (m_ph == P_GRANT)
          || (m_ph == P_HOLD);
        g = (m_ph == P_GRANT);
        return {on, m_line, g && !m_own, g && m_own,
                m_ph != P_IDLE, m_tmo};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {tx_ctrl, tx_line, syn_gnt, cmd_gnt, busy, tmo};
    endfunction

    initial begin
        m_ph = P_IDLE;
        m_own = 1'b0;
        m_left = 0;
        m_fresh = 1'b0;
        m_tmo = 1'b0;
        m_line = 1'b1;
        forever begin
            @(posedge clk_sys);
            if (rst_n !== 1'b1) begin
                m_ph = P_IDLE;
                m_own = 1'b0;
                m_tmo = 1'b0;
                m_line = 1'b1;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_sys);
            if (chk_en && rst_n === 1'b1) begin
                n_cmp++;
                if (dut_vec() !== m_vec()) begin
                    n_bad++;
                    $display("FAIL cycle_vec t=%0t got %b want %b",
                             $time, dut_vec(), m_vec());
                end
                n_cmp++;
                if (syn_gnt && cmd_gnt) begin
                    n_bad++;
                    $display("FAIL gnt_overlap t=%0t got 11 want <=1",
                             $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        syn_tx = 1'($urandom);
        cmd_tx = 1'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string nm, input int act,
                       input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act,
                           input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d..%0d",
                     nm, act, lo, hi);
        end
    endtask

    function automatic logic osig(input int sel);
        case (sel)
            0: return tx_ctrl;
            1: return syn_gnt;
            2: return cmd_gnt;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel,
                            input logic v, input int maxc,
                            output int n);
        n = 0;
        while (osig(sel) !== v && n < maxc) begin
            tick();
            n++;
            tmo_seen += int'(tmo);
            gnt_seen += int'(syn_gnt | cmd_gnt);
        end
        if (osig(sel) !== v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event after %0d cycles", nm, n);
        end
    endtask

    initial begin
        int n, len;
        rst_n = 1'b0;
        syn_req = 1'b0;
        cmd_req = 1'b0;
        syn_done = 1'b0;
        cmd_done = 1'b0;
        syn_tx = 1'b1;
        cmd_tx = 1'b1;
        run(3);
        chk("reset_vec", int'(dut_vec()), 6'b010000);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("post_reset_vec", int'(dut_vec()), 6'b010000);

        // single syn frame
        syn_req = 1'b1;
        tick();
        chk("req_latency", int'({tx_ctrl, busy, syn_gnt}), 3'b110);
        wait_for("syn_gnt_up", 1, 1'b1, 300, n);
        chk_rng("setup_len", n, 53, 102);
        len = 1;
        for (int i = 0; i < 300; i++) begin
            if (i == 299) begin
                syn_done = 1'b1;
                syn_req = 1'b0;
            end
            tick();
            syn_done = 1'b0;
            len += int'(syn_gnt);
        end
        chk("syn_gnt_len", len, 300);
        chk("hold_drive", int'({tx_ctrl, tx_line}), 2'b11);
        wait_for("ctrl_down", 0, 1'b0, 300, n);
        chk_rng("hold_len", n, 53, 102);
        wait_for("busy_down", 3, 1'b0, 400, n);
        chk_rng("gap_len", n, 203, 252);

        // simultaneous requests
        syn_req = 1'b1;
        cmd_req = 1'b1;
        wait_for("sim_syn_gnt", 1, 1'b1, 300, n);
        chk("sim_cmd_waits", int'(cmd_gnt), 0);
        run(20);
        syn_done = 1'b1;
        syn_req = 1'b0;
        tick();
        syn_done = 1'b0;
        wait_for("sim_cmd_gnt", 2, 1'b1, 800, n);
        chk_rng("sim_turnaround", n, 310, 457);
        run(10);
        cmd_done = 1'b1;
        cmd_req = 1'b0;
        tick();
        cmd_done = 1'b0;
        wait_for("sim_idle", 3, 1'b0, 600, n);

        // syn request during cmd frame, non-owner done ignored
        cmd_req = 1'b1;
        wait_for("np_cmd_gnt", 2, 1'b1, 300, n);
        run(5);
        syn_req = 1'b1;
        run(50);
        syn_done = 1'b1;
        tick();
        syn_done = 1'b0;
        run(50);
        chk("no_preempt", int'({syn_gnt, cmd_gnt}), 2'b01);
        cmd_done = 1'b1;
        cmd_req = 1'b0;
        tick();
        cmd_done = 1'b0;
        chk("np_cmd_off", int'(cmd_gnt), 0);
        wait_for("np_syn_gnt", 1, 1'b1, 800, n);
        chk_rng("np_turnaround", n, 310, 457);
        syn_done = 1'b1;
        syn_req = 1'b0;
        tick();
        syn_done = 1'b0;
        wait_for("np_idle", 3, 1'b0, 600, n);

        // timeout and re-grant
        cmd_req = 1'b1;
        wait_for("to_gnt", 2, 1'b1, 300, n);
        tmo_seen = 0;
        wait_for("to_drop", 2, 1'b0, 5200, n);
        chk_rng("to_len", n, 4953, 5002);
        chk("to_pulse", tmo_seen, 1);
        wait_for("to_regnt", 2, 1'b1, 800, n);
        chk("to_pulse_once", tmo_seen, 1);
        cmd_done = 1'b1;
        cmd_req = 1'b0;
        tick();
        cmd_done = 1'b0;
        wait_for("to_idle", 3, 1'b0, 600, n);

        // abort in setup
        cmd_req = 1'b1;
        run(11);
        cmd_req = 1'b0;
        tick();
        chk("abort_hold", int'({tx_ctrl, busy, cmd_gnt}), 3'b110);
        gnt_seen = 0;
        wait_for("abort_idle", 3, 1'b0, 600, n);
        chk("abort_no_gnt", gnt_seen, 0);

        // async reset in grant
        syn_req = 1'b1;
        wait_for("rst_gnt", 1, 1'b1, 300, n);
        run(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", int'(dut_vec()), 6'b010000);
        syn_req = 1'b0;
        run(3);
        rst_n = 1'b1;
        tick();
        chk("reset_release", int'(dut_vec()), 6'b010000);

        // randomized traffic
        for (int i = 0; i < 40000; i++) begin
            if ($urandom_range(0, 399) == 0) syn_req = ~syn_req;
            if ($urandom_range(0, 399) == 0) cmd_req = ~cmd_req;
            syn_done = ($urandom_range(0, 149) == 0);
            cmd_done = ($urandom_range(0, 149) == 0);
            if (i == 20000) begin
                #2;
                rst_n = 1'b0;
                run(2);
                rst_n = 1'b1;
            end
            tick();
        end
        syn_done = 1'b0;
        cmd_done = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
